// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, the hard-wired zero register and
// the NOP that flush consumers load into squashed pipeline registers.
package core_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LSTALL = 2'd1,
      ST_FLUSH  = 2'd2
   } state_e;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

   function automatic logic reg_match(input logic used, input logic [4:0] rs,
                                      input logic [4:0] rd);
      return used && (rs == rd) && (rd != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard bus: ID/EX register operands in, stall/flush controls out.
interface hazard_ctrl_if;

   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] ex_rd;
   logic       ex_mem_read;
   logic       ex_redirect;
   logic       load_stall;
   logic       branch_stall;
   logic       if_id_en;
   logic       if_id_flush;
   logic       id_ex_flush;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read, ex_redirect,
      input  load_stall, branch_stall, if_id_en, if_id_flush, id_ex_flush
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read, ex_redirect,
      output load_stall, branch_stall, if_id_en, if_id_flush, id_ex_flush
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; a synchronous clear takes priority over an increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / redirect hazard sequencer for the 5-stage core: drives IF stalls,
// IF/ID hold/flush and ID/EX flush, and counts stall cycles and redirects.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int LOAD_BUBBLES = 1,
   parameter int BR_BUBBLES   = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   hazard_ctrl_if.slave     hz,
   input  logic             perf_clr,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       luh, legal;
   logic       load_stall, branch_stall, if_id_en, if_id_flush, id_ex_flush;
   logic       stall_inc, flush_inc;

   assign luh = hz.ex_mem_read &&
                (reg_match(hz.id_rs1_used, hz.id_rs1, hz.ex_rd) ||
                 reg_match(hz.id_rs2_used, hz.id_rs2, hz.ex_rd));

   assign legal = (state_q == ST_RUN) || (state_q == ST_LSTALL) || (state_q == ST_FLUSH);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      load_stall   = 1'b0;
      branch_stall = 1'b0;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      // A redirect outranks everything, including an in-progress load stall.
      if (legal && hz.ex_redirect) begin
         branch_stall = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         flush_inc    = 1'b1;
         if (BR_BUBBLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = 3'(BR_BUBBLES - 1);
         end else begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (luh) begin
                  load_stall  = 1'b1;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
                  stall_inc   = 1'b1;
                  if (LOAD_BUBBLES > 1) begin
                     state_d = ST_LSTALL;
                     cnt_d   = 3'(LOAD_BUBBLES - 1);
                  end
               end
            end
            ST_LSTALL: begin
               load_stall  = 1'b1;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
               stall_inc   = 1'b1;
               cnt_d       = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = ST_RUN;
            end
            ST_FLUSH: begin
               // The ID instruction is being squashed, so its load-use hazard is moot.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               cnt_d       = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.load_stall   = load_stall;
   assign hz.branch_stall = branch_stall;
   assign hz.if_id_en     = if_id_en;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_flush  = id_ex_flush;
   assign state_o         = state_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .clr   (perf_clr),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .clr   (perf_clr),
      .cnt   (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1/2 bubbles, 32-bit counters and
// 3/3 bubbles, 4-bit counters) share stimulus and are checked against a bubble model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_mem_read = 1'b0;
   logic       ex_redirect = 1'b0, perf_clr = 1'b0;

   hazard_ctrl_if ifa ();
   hazard_ctrl_if ifb ();

   assign ifa.id_rs1 = id_rs1;           assign ifb.id_rs1 = id_rs1;
   assign ifa.id_rs2 = id_rs2;           assign ifb.id_rs2 = id_rs2;
   assign ifa.id_rs1_used = id_rs1_used; assign ifb.id_rs1_used = id_rs1_used;
   assign ifa.id_rs2_used = id_rs2_used; assign ifb.id_rs2_used = id_rs2_used;
   assign ifa.ex_rd = ex_rd;             assign ifb.ex_rd = ex_rd;
   assign ifa.ex_mem_read = ex_mem_read; assign ifb.ex_mem_read = ex_mem_read;
   assign ifa.ex_redirect = ex_redirect; assign ifb.ex_redirect = ex_redirect;

   logic [1:0]  st_a, st_b;
   logic [31:0] sc_a, fc_a;
   logic [3:0]  sc_b, fc_b;

   hazard_ctrl #(.LOAD_BUBBLES(1), .BR_BUBBLES(2), .CNT_W(32)) u_d1 (
      .clk(clk), .rst_n(rst_n), .hz(ifa), .perf_clr(perf_clr),
      .state_o(st_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

   hazard_ctrl #(.LOAD_BUBBLES(3), .BR_BUBBLES(3), .CNT_W(4)) u_d3 (
      .clk(clk), .rst_n(rst_n), .hz(ifb), .perf_clr(perf_clr),
      .state_o(st_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

   always #5 clk = ~clk;

   // Observed outputs packed as {load_stall, branch_stall, if_id_en, if_id_flush, id_ex_flush}
   logic [4:0]  act_out [2];
   logic [1:0]  act_st  [2];
   logic [31:0] act_sc  [2];
   logic [31:0] act_fc  [2];
   assign act_out[0] = {ifa.load_stall, ifa.branch_stall, ifa.if_id_en, ifa.if_id_flush, ifa.id_ex_flush};
   assign act_out[1] = {ifb.load_stall, ifb.branch_stall, ifb.if_id_en, ifb.if_id_flush, ifb.id_ex_flush};
   assign act_st[0] = st_a;
   assign act_st[1] = st_b;
   assign act_sc[0] = sc_a;
   assign act_sc[1] = {28'd0, sc_b};
   assign act_fc[0] = fc_a;
   assign act_fc[1] = {28'd0, fc_b};

   localparam logic [4:0] IDLE = 5'b00100;

   int checks = 0;
   int errors = 0;

   // Reference model: outstanding bubble counts plus event totals.
   int          rem_s [2];
   int          rem_f [2];
   logic [31:0] m_stalls [2];
   logic [31:0] m_flushes [2];
   logic [4:0]  exp_out [2];

   function automatic int lb(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int brb(input int i);
      return (i == 0) ? 2 : 3;
   endfunction

   function automatic logic [31:0] cmax(input int i);
      return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
   endfunction

   function automatic bit luh_ref();
      if (!ex_mem_read || ex_rd == 5'd0) return 1'b0;
      return (id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd);
   endfunction

   function automatic logic [1:0] exp_state(input int i);
      if (rem_f[i] > 0) return 2'd2;
      if (rem_s[i] > 0) return 2'd1;
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         rem_s[i] = 0; rem_f[i] = 0; m_stalls[i] = '0; m_flushes[i] = '0;
      end
   endtask

   task automatic model_comb();
      for (int i = 0; i < 2; i++) begin
         if (ex_redirect)                     exp_out[i] = 5'b01111;
         else if (rem_f[i] > 0)               exp_out[i] = 5'b00111;
         else if (rem_s[i] > 0 || luh_ref())  exp_out[i] = 5'b10001;
         else                                 exp_out[i] = IDLE;
      end
   endtask

   task automatic model_clk();
      bit inc_s, inc_f;
      for (int i = 0; i < 2; i++) begin
         inc_f = ex_redirect;
         inc_s = !ex_redirect && rem_f[i] == 0 && (rem_s[i] > 0 || luh_ref());
         if (ex_redirect) begin
            rem_f[i] = brb(i) - 1;
            rem_s[i] = 0;
         end else if (rem_f[i] > 0) rem_f[i]--;
         else if (rem_s[i] > 0)     rem_s[i]--;
         else if (luh_ref())        rem_s[i] = lb(i) - 1;
         if (perf_clr) begin
            m_stalls[i] = '0; m_flushes[i] = '0;
         end else begin
            if (inc_s && m_stalls[i] != cmax(i))  m_stalls[i]++;
            if (inc_f && m_flushes[i] != cmax(i)) m_flushes[i]++;
         end
      end
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic redir, input logic clr);
      id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      ex_rd = rd; ex_mem_read = mr; ex_redirect = redir; perf_clr = clr;
   endtask

   // One clock: compare combinational outputs before the edge, registered state after it.
   task automatic step(input string tag);
      #1;
      model_comb();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_out[i] !== exp_out[i]) begin
            errors++;
            $display("FAIL %s out[%0d] got %b want %b", tag, i, act_out[i], exp_out[i]);
         end
      end
      @(posedge clk);
      model_clk();
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_st[i] !== exp_state(i) || act_sc[i] !== m_stalls[i] || act_fc[i] !== m_flushes[i]) begin
            errors++;
            $display("FAIL %s regs[%0d] got st=%0d sc=%0d fc=%0d want st=%0d sc=%0d fc=%0d", tag, i,
                     act_st[i], act_sc[i], act_fc[i], exp_state(i), m_stalls[i], m_flushes[i]);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_out[i] !== IDLE || act_st[i] !== 2'd0 || act_sc[i] !== 32'd0 || act_fc[i] !== 32'd0) begin
            errors++;
            $display("FAIL reset[%0d] got out=%b st=%0d sc=%0d fc=%0d want out=%b st=0 sc=0 fc=0",
                     i, act_out[i], act_st[i], act_sc[i], act_fc[i], IDLE);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_load_use();
      @(negedge clk);
      set_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      step("load_use");
      checks++;
      if (act_sc[0] !== 32'd1 || act_st[0] !== 2'd0) begin
         errors++;
         $display("FAIL load_use_cnt got sc=%0d st=%0d want sc=1 st=0", act_sc[0], act_st[0]);
      end
      @(negedge clk);
      set_in(5'd6, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      step("load_use_tail");
      step("load_use_tail2");
      step("load_use_tail3");
   endtask

   task automatic test_x0();
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (act_out[0] !== IDLE || act_out[1] !== IDLE) begin
         errors++;
         $display("FAIL x0_idle got %b/%b want %b", act_out[0], act_out[1], IDLE);
      end
      step("x0");
   endtask

   task automatic test_redirect();
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      step("redir_clr");
      @(negedge clk);
      ex_redirect = 1'b1; perf_clr = 1'b0;
      step("redir_c0");
      @(negedge clk);
      ex_redirect = 1'b0;
      #1;
      checks++;
      if (act_out[0] !== 5'b00111 || act_st[0] !== 2'd2) begin
         errors++;
         $display("FAIL redir_c1 got out=%b st=%0d want out=00111 st=2", act_out[0], act_st[0]);
      end
      step("redir_c1");
      checks++;
      if (act_st[0] !== 2'd0 || act_fc[0] !== 32'd1) begin
         errors++;
         $display("FAIL redir_c2 got st=%0d fc=%0d want st=0 fc=1", act_st[0], act_fc[0]);
      end
      step("redir_c2");
   endtask

   task automatic test_abort();
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      step("abort_clr");
      @(negedge clk);
      set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      step("abort_luh");
      @(negedge clk);
      ex_mem_read = 1'b0;
      step("abort_ls1");
      @(negedge clk);
      ex_redirect = 1'b1;
      step("abort_redir");
      checks++;
      if (act_sc[1] !== 32'd2 || act_fc[1] !== 32'd1 || act_st[1] !== 2'd2) begin
         errors++;
         $display("FAIL abort got sc=%0d fc=%0d st=%0d want sc=2 fc=1 st=2",
                  act_sc[1], act_fc[1], act_st[1]);
      end
      @(negedge clk);
      ex_redirect = 1'b0;
      repeat (3) step("abort_drain");
   endtask

   task automatic test_saturate();
      @(negedge clk);
      force u_d1.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
      #1;
      release u_d1.u_stall_cnt.cnt_q;
      m_stalls[0] = 32'hFFFF_FFFF;
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      step("sat_hold");
      checks++;
      if (act_sc[0] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sat_hold got %h want ffffffff", act_sc[0]);
      end
      @(negedge clk);
      perf_clr = 1'b1;
      step("sat_clr");
      checks++;
      if (act_sc[0] !== 32'd0 || act_sc[1] !== 32'd0) begin
         errors++;
         $display("FAIL sat_clr got %0d/%0d want 0/0", act_sc[0], act_sc[1]);
      end
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) step("sat_drain");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ex_redirect = 1'b1;
      step("arst_redir");
      @(negedge clk);
      ex_redirect = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_out[i] !== IDLE || act_st[i] !== 2'd0) begin
            errors++;
            $display("FAIL arst[%0d] got out=%b st=%0d want out=%b st=0", i, act_out[i], act_st[i], IDLE);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      step("arst_after");
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3));
         step("random");
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      test_reset();
      test_load_use();
      test_x0();
      test_redirect();
      test_abort();
      test_saturate();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
